// File: rtl/vote_trip_monitor.sv
// N-voter fault monitor: per-voter persistence filters feed a masked fail count,
// which drives a sticky OK/PENDING/TRIPPED state machine with a trip-event counter.

module vote_filter #(
    parameter int PERSIST = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sample,
    input  logic i_vote,
    output logic o_filt
);
    localparam int SW = (PERSIST > 1) ? $clog2(PERSIST) : 1;

    logic [SW-1:0] r_stab;
    logic          r_filt;

    // filt flips on the PERSIST-th consecutive sample that disagrees with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_stab <= '0;
        end else if (i_sample) begin
            if (i_vote == r_filt) begin
                r_stab <= '0;
            end else if (r_stab == SW'(PERSIST - 1)) begin
                r_filt <= i_vote;
                r_stab <= '0;
            end else begin
                r_stab <= r_stab + SW'(1);
            end
        end
    end

    assign o_filt = r_filt;
endmodule

module vote_trip_monitor #(
    parameter  int N_VOTERS     = 8,
    parameter  int PERSIST      = 3,
    parameter  int TRIP_SAMPLES = 2,
    parameter  int EVT_W        = 4,
    localparam int CW           = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [N_VOTERS-1:0] votes,
    input  logic [N_VOTERS-1:0] voter_en,
    input  logic [CW-1:0]       threshold,
    input  logic                clear,
    output logic [CW-1:0]       fail_count,
    output logic                over,
    output logic                pending,
    output logic                tripped,
    output logic [EVT_W-1:0]    trip_events
);
    localparam int PW = (TRIP_SAMPLES > 1) ? $clog2(TRIP_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {ST_OK, ST_PEND, ST_TRIP} state_t;

    logic [N_VOTERS-1:0] w_filt;
    logic [N_VOTERS-1:0] w_masked;
    logic [CW-1:0]       w_cnt;
    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_pend, w_pend_nxt;
    logic                w_enter;
    logic [EVT_W-1:0]    r_evt;

    for (genvar g = 0; g < N_VOTERS; g++) begin : g_filt
        vote_filter #(.PERSIST(PERSIST)) u_filt (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_sample (sample_en),
            .i_vote   (votes[g]),
            .o_filt   (w_filt[g])
        );
    end

    assign w_masked = w_filt & voter_en;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_VOTERS; i++) w_cnt = w_cnt + CW'(w_masked[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fail_count <= '0;
        else        fail_count <= w_cnt;
    end

    assign over = (fail_count > threshold);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_enter     = 1'b0;
        if (clear) begin
            w_state_nxt = ST_OK;
            w_pend_nxt  = '0;
        end else if (sample_en) begin
            case (r_state)
                ST_OK: if (over) begin
                    if (TRIP_SAMPLES == 1) begin
                        w_state_nxt = ST_TRIP;
                        w_enter     = 1'b1;
                    end else begin
                        w_state_nxt = ST_PEND;
                        w_pend_nxt  = PW'(1);
                    end
                end
                ST_PEND: if (over) begin
                    if (r_pend + PW'(1) == PW'(TRIP_SAMPLES)) begin
                        w_state_nxt = ST_TRIP;
                        w_pend_nxt  = '0;
                        w_enter     = 1'b1;
                    end else begin
                        w_pend_nxt  = r_pend + PW'(1);
                    end
                end else begin
                    w_state_nxt = ST_OK;
                    w_pend_nxt  = '0;
                end
                ST_TRIP: ;
                default: begin
                    w_state_nxt = ST_OK;
                    w_pend_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OK;
            r_pend  <= '0;
            r_evt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_enter && (r_evt != {EVT_W{1'b1}})) r_evt <= r_evt + EVT_W'(1);
        end
    end

    assign pending     = (r_state == ST_PEND);
    assign tripped     = (r_state == ST_TRIP);
    assign trip_events = r_evt;
endmodule

// File: tb/tb_vote_trip_monitor.sv
// Randomised + directed bench for vote_trip_monitor against a run-length based reference model.
module tb_vote_trip_monitor;
    localparam int N       = 8;
    localparam int PERSIST = 3;
    localparam int TRIPS   = 2;
    localparam int EVT_W   = 2;
    localparam int CW      = $clog2(N + 1);
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_en = 1'b0;
    logic [N-1:0]     votes = '0;
    logic [N-1:0]     voter_en = '0;
    logic [CW-1:0]    threshold = '0;
    logic             clear = 1'b0;
    logic [CW-1:0]    fail_count;
    logic             over, pending, tripped;
    logic [EVT_W-1:0] trip_events;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit m_filt [N];
    bit m_last [N];
    int m_run  [N];
    int m_fc   = 0;
    int m_orun = 0;
    bit m_trip = 1'b0;
    int m_evt  = 0;

    vote_trip_monitor #(
        .N_VOTERS(N), .PERSIST(PERSIST), .TRIP_SAMPLES(TRIPS), .EVT_W(EVT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .votes(votes),
        .voter_en(voter_en), .threshold(threshold), .clear(clear),
        .fail_count(fail_count), .over(over), .pending(pending),
        .tripped(tripped), .trip_events(trip_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A voter's filtered value becomes v once the trailing run of samples equal
    // to v reaches PERSIST; the trip fires after TRIPS consecutive over samples.
    always @(posedge clk or negedge rst_n) begin
        int nfc;
        bit ov;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_filt[i] = 0; m_last[i] = 0; m_run[i] = 0;
            end
            m_fc = 0; m_orun = 0; m_trip = 0; m_evt = 0;
        end else begin
            ov  = (m_fc > int'(threshold));
            nfc = 0;
            for (int i = 0; i < N; i++) if (m_filt[i] && voter_en[i]) nfc++;
            if (sample_en) begin
                for (int i = 0; i < N; i++) begin
                    if (m_run[i] > 0 && votes[i] == m_last[i]) m_run[i]++;
                    else m_run[i] = 1;
                    m_last[i] = votes[i];
                    if (votes[i] != m_filt[i] && m_run[i] >= PERSIST) m_filt[i] = votes[i];
                end
            end
            if (clear) begin
                m_trip = 0; m_orun = 0;
            end else if (sample_en && !m_trip) begin
                if (ov) begin
                    m_orun++;
                    if (m_orun >= TRIPS) begin
                        m_trip = 1; m_orun = 0;
                        if (m_evt < EVT_MAX) m_evt++;
                    end
                end else begin
                    m_orun = 0;
                end
            end
            m_fc = nfc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fail_count", int'(fail_count), m_fc);
            chk("over", int'(over), int'(m_fc > int'(threshold)));
            chk("pending", int'(pending), int'(!m_trip && m_orun > 0));
            chk("tripped", int'(tripped), int'(m_trip));
            chk("trip_events", int'(trip_events), m_evt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #11;
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_fail_count", int'(fail_count), 0);
        chk("rst_tripped", int'(tripped), 0);
        chk("rst_events", int'(trip_events), 0);

        // basic trip
        votes = 8'h07; voter_en = 8'hFF; threshold = 2; sample_en = 1'b1;
        cyc(3);
        chk("lit_fc_before", int'(fail_count), 0);
        cyc(1);
        chk("lit_fc_3", int'(fail_count), 3);
        chk("lit_over", int'(over), 1);
        chk("lit_not_pend", int'(pending), 0);
        cyc(1);
        chk("lit_pending", int'(pending), 1);
        cyc(1);
        chk("lit_tripped", int'(tripped), 1);
        chk("lit_events1", int'(trip_events), 1);

        // sticky, then clear
        votes = 8'h00;
        cyc(20);
        chk("lit_sticky", int'(tripped), 1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("lit_cleared", int'(tripped), 0);

        // clear coinciding with the second over sample
        votes = 8'h07;
        cyc(4);
        chk("lit_over2", int'(over), 1);
        cyc(1);
        chk("lit_pending2", int'(pending), 1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("lit_clear_wins", int'(tripped), 0);
        chk("lit_clear_evt", int'(trip_events), 1);
        cyc(1);
        chk("lit_fresh_pend", int'(pending), 1);
        cyc(1);
        chk("lit_retrip", int'(tripped), 1);
        chk("lit_events2", int'(trip_events), 2);

        // saturation
        for (int k = 0; k < 3; k++) begin
            clear = 1'b1; cyc(1); clear = 1'b0;
            cyc(2);
        end
        chk("lit_sat", int'(trip_events), 3);

        // glitch rejection
        votes = 8'h00; threshold = 0;
        cyc(6);
        votes = 8'h01; cyc(2);
        votes = 8'h00; cyc(5);
        chk("lit_glitch_fc", int'(fail_count), 0);
        chk("lit_glitch_over", int'(over), 0);

        // masking
        clear = 1'b1; votes = 8'hFF; voter_en = 8'h0F; threshold = 4;
        cyc(1); clear = 1'b0;
        cyc(10);
        chk("lit_mask_fc", int'(fail_count), 4);
        chk("lit_mask_over", int'(over), 0);
        chk("lit_mask_ok", int'(pending | tripped), 0);

        // pending abort
        threshold = 3; cyc(1);
        chk("lit_abort_pend", int'(pending), 1);
        threshold = 4; cyc(1);
        chk("lit_abort_ok", int'(pending), 0);
        chk("lit_abort_trip", int'(tripped), 0);
        chk("lit_abort_evt", int'(trip_events), 3);

        // async reset mid-PENDING
        threshold = 3; cyc(1);
        chk("lit_pend_pre_rst", int'(pending), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_fc", int'(fail_count), 0);
        chk("async_over", int'(over), 0);
        chk("async_pend", int'(pending), 0);
        chk("async_trip", int'(tripped), 0);
        chk("async_evt", int'(trip_events), 0);
        cyc(2);
        rst_n = 1'b1;

        // randomised traffic
        voter_en = 8'hFF; threshold = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) votes[i] = ~votes[i];
            sample_en = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) threshold = CW'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) voter_en = N'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1'b1; clear = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
